carpark_occupancy: RTL and testbench

Downstream occupancy and exit-lane stage of the car park. It consumes the one-cycle admit pulse produced by the entry gate controller, drives an exit-lane state machine from a front/back sensor pair, and maintains the live car count. It returns `entry_allow` to the entry gate so that no admission is granted while the lot is full.

---
 rtl/carpark_pkg.sv | 15 +
 rtl/occupancy_counter.sv | 51 +++++
 rtl/carpark_occupancy.sv | 99 +++++++++
 tb/tb_carpark_occupancy.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/carpark_pkg.sv
// Shared car park constants and the exit-lane state encoding.
// The entry gate controller uses the same constants.
package carpark_pkg;

  localparam int CARPARK_CAPACITY = 12;
  localparam int CARPARK_CNT_W    = 4;
  localparam int EXIT_TIMEOUT     = 15;

  typedef enum logic [1:0] {
    X_IDLE = 2'd0,
    X_OPEN = 2'd1,
    X_PASS = 2'd2
  } exit_state_t;

endpackage

// File: rtl/occupancy_counter.sv
// Live car count with full/empty flags and the rejected-entry pulse.
// The inc input carries the raw admit request. The counter itself masks
// the request while the lot is full, so fullness is always judged on the
// count as it stood before this cycle's update.
module occupancy_counter
  import carpark_pkg::*;
#(
  parameter int CAPACITY = CARPARK_CAPACITY,
  parameter int CNT_W    = CARPARK_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             entry_error
);

  // Saturating count update. A simultaneous inc and dec cancel out.
  function automatic logic [CNT_W-1:0] sat_update(input logic [CNT_W-1:0] cnt,
                                                  input logic             up,
                                                  input logic             dn);
    logic [CNT_W-1:0] res;
    res = cnt;
    if (up && !dn && (cnt != CNT_W'(CAPACITY)))
      res = cnt + CNT_W'(1);
    else if (dn && !up && (cnt != '0))
      res = cnt - CNT_W'(1);
    return res;
  endfunction

  logic inc_ok;

  assign inc_ok = inc & ~full;
  assign full   = (count == CNT_W'(CAPACITY));
  assign empty  = (count == '0);

  // Count register and registered entry-error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count       <= '0;
      entry_error <= 1'b0;
    end else begin
      count       <= sat_update(count, inc_ok, dec);
      entry_error <= inc & full;
    end
  end

endmodule

// File: rtl/carpark_occupancy.sv
// Occupancy and exit-lane stage: exit barrier FSM with a sensor timeout,
// plus the live count that feeds entry_allow back to the entry gate.
module carpark_occupancy
  import carpark_pkg::*;
#(
  parameter int CAPACITY = CARPARK_CAPACITY,
  parameter int CNT_W    = CARPARK_CNT_W,
  parameter int TIMEOUT  = EXIT_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entry_pulse,
  input  logic             exit_fsensor,
  input  logic             exit_bsensor,
  output logic [CNT_W-1:0] occupancy,
  output logic             lot_full,
  output logic             lot_empty,
  output logic             entry_allow,
  output logic             exit_gate_open,
  output logic             entry_error,
  output logic             exit_error
);

  localparam int TW = $clog2(TIMEOUT + 1);

  exit_state_t   state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          xerr_d;
  logic          dec;

  occupancy_counter #(
    .CAPACITY (CAPACITY),
    .CNT_W    (CNT_W)
  ) u_counter (
    .clk         (clk),
    .reset       (reset),
    .inc         (entry_pulse),
    .dec         (dec),
    .count       (occupancy),
    .full        (lot_full),
    .empty       (lot_empty),
    .entry_error (entry_error)
  );

  assign entry_allow    = ~lot_full;
  assign exit_gate_open = (state_q == X_OPEN) || (state_q == X_PASS);

  // Exit FSM next state, timeout count, error request and decrement strobe.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    xerr_d  = 1'b0;
    dec     = 1'b0;
    case (state_q)
      X_IDLE: begin
        if (exit_fsensor) begin
          if (!lot_empty) begin
            state_d = X_OPEN;
            tcnt_d  = '0;
          end else begin
            xerr_d = 1'b1;
          end
        end
      end
      X_OPEN: begin
        if (exit_bsensor) begin
          state_d = X_PASS;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
          if (tcnt_q == TW'(TIMEOUT - 1)) begin
            state_d = X_IDLE;
            xerr_d  = 1'b1;
          end
        end
      end
      X_PASS: begin
        if (!exit_bsensor && !exit_fsensor) begin
          state_d = X_IDLE;
          dec     = 1'b1;
        end
      end
      default: state_d = X_IDLE;
    endcase
  end

  // Exit FSM state, timeout counter and registered exit-error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= X_IDLE;
      tcnt_q     <= '0;
      exit_error <= 1'b0;
    end else begin
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      exit_error <= xerr_d;
    end
  end

endmodule

// File: tb/tb_carpark_occupancy.sv
// Bench for carpark_occupancy: directed scenarios plus randomized traffic,
// all checked against a behavioural lot/barrier model.
module tb_carpark_occupancy;

  localparam int CAP = 12;
  localparam int TO  = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic       entry_pulse, exit_fsensor, exit_bsensor;
  logic [3:0] occupancy;
  logic       lot_full, lot_empty, entry_allow, exit_gate_open;
  logic       entry_error, exit_error;

  int errors = 0;
  int checks = 0;

  // Behavioural model: cars in the lot, barrier raised, car under the
  // barrier, cycles spent waiting for the car to move, error pulses.
  int m_occ;
  bit m_open, m_pass;
  int m_wait;
  bit m_eerr, m_xerr;

  carpark_occupancy #(.CAPACITY(CAP), .CNT_W(4), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .entry_pulse    (entry_pulse),
    .exit_fsensor   (exit_fsensor),
    .exit_bsensor   (exit_bsensor),
    .occupancy      (occupancy),
    .lot_full       (lot_full),
    .lot_empty      (lot_empty),
    .entry_allow    (entry_allow),
    .exit_gate_open (exit_gate_open),
    .entry_error    (entry_error),
    .exit_error     (exit_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_occ  = 0;
    m_open = 0;
    m_pass = 0;
    m_wait = 0;
    m_eerr = 0;
    m_xerr = 0;
  endtask

  task automatic compare_all();
    check("occupancy", 32'(occupancy), 32'(m_occ));
    check("lot_full", 32'(lot_full), 32'(m_occ == CAP));
    check("lot_empty", 32'(lot_empty), 32'(m_occ == 0));
    check("entry_allow", 32'(entry_allow), 32'(m_occ != CAP));
    check("gate_open", 32'(exit_gate_open), 32'(m_open));
    check("entry_error", 32'(entry_error), 32'(m_eerr));
    check("exit_error", 32'(exit_error), 32'(m_xerr));
  endtask

  // Apply one cycle of inputs, advance the model, and compare after the edge.
  task automatic step(input bit e, input bit f, input bit b);
    int inc, dec;
    entry_pulse  = e;
    exit_fsensor = f;
    exit_bsensor = b;
    inc    = (e && m_occ < CAP) ? 1 : 0;
    m_eerr = e && (m_occ == CAP);
    m_xerr = 0;
    dec    = 0;
    if (!m_open) begin
      if (f) begin
        if (m_occ > 0) begin
          m_open = 1;
          m_pass = 0;
          m_wait = 0;
        end else begin
          m_xerr = 1;
        end
      end
    end else if (!m_pass) begin
      if (b) begin
        m_pass = 1;
      end else begin
        m_wait++;
        if (m_wait == TO) begin
          m_open = 0;
          m_xerr = 1;
        end
      end
    end else if (!b && !f) begin
      m_open = 0;
      m_pass = 0;
      dec    = 1;
    end
    m_occ = m_occ + inc - dec;
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Reset asserted between edges: outputs must clear before any clock edge.
  task automatic async_reset();
    reset = 1'b1;
    #1;
    check("arst_gate", 32'(exit_gate_open), 32'd0);
    check("arst_occ", 32'(occupancy), 32'd0);
    check("arst_empty", 32'(lot_empty), 32'd1);
    model_reset();
    entry_pulse  = 1'b0;
    exit_fsensor = 1'b0;
    exit_bsensor = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    compare_all();
  endtask

  task automatic exit_seq(input bit e_last);
    step(0, 1, 0);
    step(0, 1, 1);
    step(0, 0, 1);
    step(e_last, 0, 0);
  endtask

  initial begin
    reset        = 1'b1;
    entry_pulse  = 1'b0;
    exit_fsensor = 1'b0;
    exit_bsensor = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    reset = 1'b0;

    // Three entries two cycles apart.
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0);
      step(0, 0, 0);
    end

    // Fill to capacity, then a rejected 13th entry.
    for (int i = 0; i < 9; i++) step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);

    // Exit at capacity with a rejected entry on the closing edge.
    exit_seq(1'b1);
    step(0, 0, 0);

    // Normal exit from five cars.
    async_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    exit_seq(1'b0);

    // Entry and exit in the same cycle at six cars.
    for (int i = 0; i < 2; i++) step(1, 0, 0);
    exit_seq(1'b1);

    // Exit timeout with the back sensor never seen.
    step(0, 1, 0);
    for (int i = 0; i < TO + 2; i++) step(0, 0, 0);

    // Exit request on an empty lot, sensor held for a few cycles.
    async_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    step(0, 0, 0);

    // Asynchronous reset while a car is under the barrier at seven cars.
    for (int i = 0; i < 7; i++) step(1, 0, 0);
    step(0, 1, 0);
    step(0, 1, 1);
    async_reset();

    // Randomized traffic: a filling phase then a draining phase.
    for (int i = 0; i < 800; i++) begin
      int pe;
      pe = (i < 400) ? 60 : 20;
      step($urandom_range(0, 99) < pe,
           $urandom_range(0, 99) < 35,
           $urandom_range(0, 99) < 35);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
